// File: rtl/ddr_axi_master.sv
// Cache line bridge onto a 128-bit AXI4 master: one single-beat write-back and one refill at a time.
// Optional macro DDR_WR_BEFORE_RD_EN holds refill address issue until any write-back has its response.
module ddr_axi_master (
   input  logic          clk,
   input  logic          rst,
   input  logic [127:0]  wr_data,
   input  logic [26:0]   wr_addr,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [26:0]   rd_addr,
   input  logic          rd_avalid,
   output logic          rd_aready,
   output logic [127:0]  rd_data,
   output logic          rd_valid,
   input  logic          rd_dready,
   output logic [26:0]   M_AXI_AWADDR,
   output logic [7:0]    M_AXI_AWLEN,
   output logic [2:0]    M_AXI_AWSIZE,
   output logic [1:0]    M_AXI_AWBURST,
   output logic          M_AXI_AWLOCK,
   output logic [3:0]    M_AXI_AWCACHE,
   output logic [2:0]    M_AXI_AWPROT,
   output logic [3:0]    M_AXI_AWQOS,
   output logic          M_AXI_AWVALID,
   input  logic          M_AXI_AWREADY,
   output logic [127:0]  M_AXI_WDATA,
   output logic [15:0]   M_AXI_WSTRB,
   output logic          M_AXI_WLAST,
   output logic          M_AXI_WVALID,
   input  logic          M_AXI_WREADY,
   input  logic [1:0]    M_AXI_BRESP,
   input  logic          M_AXI_BVALID,
   output logic          M_AXI_BREADY,
   output logic [26:0]   M_AXI_ARADDR,
   output logic [7:0]    M_AXI_ARLEN,
   output logic [2:0]    M_AXI_ARSIZE,
   output logic [1:0]    M_AXI_ARBURST,
   output logic [1:0]    M_AXI_ARLOCK,
   output logic [3:0]    M_AXI_ARCACHE,
   output logic [2:0]    M_AXI_ARPROT,
   output logic [3:0]    M_AXI_ARQOS,
   output logic          M_AXI_ARVALID,
   input  logic          M_AXI_ARREADY,
   input  logic [127:0]  M_AXI_RDATA,
   input  logic [1:0]    M_AXI_RRESP,
   input  logic          M_AXI_RLAST,
   input  logic          M_AXI_RVALID,
   output logic          M_AXI_RREADY
);

   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;
   logic     aw_done, w_done;
   logic     ar_go;
   logic     unused_inputs;

   // Every transfer is one full 16-byte beat, so the burst attributes never change.
   assign M_AXI_AWLEN   = 8'd0;
   assign M_AXI_AWSIZE  = 3'b100;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'd0;
   assign M_AXI_AWQOS   = 4'd0;
   assign M_AXI_WSTRB   = 16'hFFFF;
   assign M_AXI_WLAST   = M_AXI_WVALID;
   assign M_AXI_ARLEN   = 8'd0;
   assign M_AXI_ARSIZE  = 3'b100;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 2'd0;
   assign M_AXI_ARCACHE = 4'b0011;
   assign M_AXI_ARPROT  = 3'd0;
   assign M_AXI_ARQOS   = 4'd0;
   assign unused_inputs = ^{M_AXI_BRESP, M_AXI_RRESP, M_AXI_RLAST};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state      <= W_IDLE;
         aw_done      <= 1'b0;
         w_done       <= 1'b0;
         M_AXI_AWADDR <= '0;
         M_AXI_WDATA  <= '0;
      end else begin
         w_state <= w_next;
         if (w_state == W_IDLE && wr_valid) begin
            M_AXI_AWADDR <= wr_addr;
            M_AXI_WDATA  <= wr_data;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
         end
         if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
         if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      end
   end

   // AW and W complete independently; the response is awaited only once both have handshaken.
   always_comb begin
      w_next        = w_state;
      wr_ready      = 1'b0;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      case (w_state)
         W_IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid) w_next = W_SEND;
         end
         W_SEND: begin
            M_AXI_AWVALID = !aw_done;
            M_AXI_WVALID  = !w_done;
            if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) w_next = W_RESP;
         end
         W_RESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= R_IDLE;
         M_AXI_ARADDR <= '0;
         rd_data      <= '0;
      end else begin
         r_state <= r_next;
         if (r_state == R_IDLE && rd_avalid) M_AXI_ARADDR <= rd_addr;
         if (r_state == R_DATA && M_AXI_RVALID) rd_data <= M_AXI_RDATA;
      end
   end

   always_comb begin
      r_next        = r_state;
      rd_aready     = 1'b0;
      rd_valid      = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      ar_go         = 1'b0;
      case (r_state)
         R_IDLE: begin
            rd_aready = 1'b1;
            if (rd_avalid) r_next = R_ADDR;
         end
         R_ADDR: begin
`ifdef DDR_WR_BEFORE_RD_EN
            ar_go = (w_state == W_IDLE);
`else
            ar_go = 1'b1;
`endif
            M_AXI_ARVALID = ar_go;
            if (ar_go && M_AXI_ARREADY) r_next = R_DATA;
         end
         R_DATA: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) r_next = R_HOLD;
         end
         R_HOLD: begin
            rd_valid = 1'b1;
            if (rd_dready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ddr_axi_master.sv
// Directed self-checking bench for ddr_axi_master; inputs change on the falling edge, outputs sampled there too.
module tb_ddr_axi_master;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [127:0]  wr_data = '0;
   logic [26:0]   wr_addr = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [26:0]   rd_addr = '0;
   logic          rd_avalid = 1'b0;
   logic          rd_aready;
   logic [127:0]  rd_data;
   logic          rd_valid;
   logic          rd_dready = 1'b0;
   logic [26:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awlock;
   logic [3:0]    awcache;
   logic [2:0]    awprot;
   logic [3:0]    awqos;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [127:0]  wdata;
   logic [15:0]   wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [1:0]    bresp = 2'b00;
   logic          bvalid = 1'b0;
   logic          bready;
   logic [26:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [1:0]    arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic [3:0]    arqos;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [127:0]  rdata = '0;
   logic [1:0]    rresp = 2'b00;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;

   int checks = 0;
   int failures = 0;
   logic [26:0]  aw_log[$];
   logic [127:0] w_log[$];
   logic         exp_ar;

   ddr_axi_master dut (
      .clk(clk), .rst(rst),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
      .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
      .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   // Slave-side record of every accepted AW and W beat.
   always @(posedge clk) begin
      if (!rst && awvalid && awready) aw_log.push_back(awaddr);
      if (!rst && wvalid && wready)   w_log.push_back(wdata);
   end

   task automatic test_reset();
      #1;
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0 || bready !== 1'b0 || rready !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valids: got aw=%b w=%b ar=%b b=%b r=%b rv=%b required all 0", awvalid, wvalid, arvalid, bready, rready, rd_valid); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1 || rd_aready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got wr_ready=%b rd_aready=%b required 1 1", wr_ready, rd_aready); end
      checks++; if (awaddr !== 27'd0 || araddr !== 27'd0 || wdata !== 128'd0 || rd_data !== 128'd0) begin failures++; $display("[TB] FAIL reset_regs: got awaddr=%h araddr=%h wdata=%h rd_data=%h required 0", awaddr, araddr, wdata, rd_data); end
      checks++; if ({awlen, awsize, awburst, awlock, awcache, awprot, awqos} !== {8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}) begin failures++; $display("[TB] FAIL aw_consts: got len=%h size=%b burst=%b lock=%b cache=%b prot=%b qos=%h", awlen, awsize, awburst, awlock, awcache, awprot, awqos); end
      checks++; if ({arlen, arsize, arburst, arlock, arcache, arprot, arqos, wstrb} !== {8'd0, 3'b100, 2'b01, 2'd0, 4'b0011, 3'd0, 4'd0, 16'hFFFF}) begin failures++; $display("[TB] FAIL ar_consts: got len=%h size=%b burst=%b lock=%b cache=%b prot=%b qos=%h wstrb=%h", arlen, arsize, arburst, arlock, arcache, arprot, arqos, wstrb); end
   endtask

   task automatic test_write();
      int n0;
      n0 = aw_log.size();
      wr_addr = 27'h0001230; wr_data = {16{8'hA5}}; wr_valid = 1'b1; awready = 1'b1; wready = 1'b1;
      @(negedge clk); wr_valid = 1'b0; wr_data = '0; wr_addr = '0;
      checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wlast !== 1'b1 || wr_ready !== 1'b0 || bready !== 1'b0) begin failures++; $display("[TB] FAIL wr_send: got aw=%b w=%b last=%b wr_ready=%b bready=%b required 1 1 1 0 0", awvalid, wvalid, wlast, wr_ready, bready); end
      checks++; if (awaddr !== 27'h0001230 || wdata !== {16{8'hA5}} || wstrb !== 16'hFFFF) begin failures++; $display("[TB] FAIL wr_payload: got addr=%h data=%h strb=%h", awaddr, wdata, wstrb); end
      @(negedge clk); awready = 1'b0; wready = 1'b0;
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_resp: got aw=%b w=%b bready=%b wr_ready=%b required 0 0 1 0", awvalid, wvalid, bready, wr_ready); end
      @(negedge clk); bvalid = 1'b1;
      checks++; if (wr_ready !== 1'b0 || bready !== 1'b1) begin failures++; $display("[TB] FAIL wr_wait_b: got wr_ready=%b bready=%b required 0 1", wr_ready, bready); end
      @(negedge clk); bvalid = 1'b0;
      checks++; if (wr_ready !== 1'b1 || bready !== 1'b0) begin failures++; $display("[TB] FAIL wr_done: got wr_ready=%b bready=%b required 1 0", wr_ready, bready); end
      checks++; if (aw_log.size() - n0 !== 1 || w_log.size() - n0 !== 1) begin failures++; $display("[TB] FAIL wr_beats: got aw=%0d w=%0d required 1 1", aw_log.size() - n0, w_log.size() - n0); end
   endtask

   task automatic test_read();
      checks++; if (rd_aready !== 1'b1) begin failures++; $display("[TB] FAIL rd_idle: got %b required 1", rd_aready); end
      rd_addr = 27'h0004560; rd_avalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); rd_avalid = 1'b0; rd_addr = '0;
         checks++; if (arvalid !== 1'b1 || araddr !== 27'h0004560 || rd_aready !== 1'b0) begin failures++; $display("[TB] FAIL rd_arvalid_%0d: got arvalid=%b araddr=%h rd_aready=%b required 1 0004560 0", i, arvalid, araddr, rd_aready); end
         if (i == 2) arready = 1'b1;
      end
      @(negedge clk); arready = 1'b0;
      checks++; if (arvalid !== 1'b0 || rready !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_data_wait: got arvalid=%b rready=%b rd_valid=%b required 0 1 0", arvalid, rready, rd_valid); end
      rvalid = 1'b1; rdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      @(negedge clk); rvalid = 1'b0; rdata = '1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (rd_valid !== 1'b1 || rd_data !== 128'h0123456789ABCDEF0123456789ABCDEF || rready !== 1'b0) begin failures++; $display("[TB] FAIL rd_hold_%0d: got rd_valid=%b rd_data=%h rready=%b", i, rd_valid, rd_data, rready); end
         if (i == 0) @(negedge clk);
      end
      rd_dready = 1'b1;
      @(negedge clk); rd_dready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || rd_aready !== 1'b1) begin failures++; $display("[TB] FAIL rd_done: got rd_valid=%b rd_aready=%b required 0 1", rd_valid, rd_aready); end
   endtask

   task automatic test_independent_w_aw();
      wr_addr = 27'h00ABC0; wr_data = 128'h11112222333344445555666677778888; wr_valid = 1'b1;
      @(negedge clk); wr_valid = 1'b0;
      checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin failures++; $display("[TB] FAIL ind_start: got aw=%b w=%b required 1 1", awvalid, wvalid); end
      wready = 1'b1;
      @(negedge clk); wready = 1'b0;
      checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin failures++; $display("[TB] FAIL ind_w_first: got w=%b aw=%b bready=%b required 0 1 0", wvalid, awvalid, bready); end
      @(negedge clk);
      checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0 || awaddr !== 27'h00ABC0) begin failures++; $display("[TB] FAIL ind_aw_hold: got w=%b aw=%b bready=%b awaddr=%h", wvalid, awvalid, bready, awaddr); end
      awready = 1'b1;
      @(negedge clk); awready = 1'b0;
      checks++; if (awvalid !== 1'b0 || bready !== 1'b1) begin failures++; $display("[TB] FAIL ind_resp: got aw=%b bready=%b required 0 1", awvalid, bready); end
      bvalid = 1'b1;
      @(negedge clk); bvalid = 1'b0;
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL ind_done: got wr_ready=%b required 1", wr_ready); end
   endtask

   task automatic test_concurrent();
      wr_addr = 27'h0007700; wr_data = 128'hCAFE; wr_valid = 1'b1;
      rd_addr = 27'h0007700; rd_avalid = 1'b1;
      awready = 1'b1; wready = 1'b1; arready = 1'b1;
      @(negedge clk); wr_valid = 1'b0; rd_avalid = 1'b0;
      checks++; if (wr_ready !== 1'b0 || rd_aready !== 1'b0) begin failures++; $display("[TB] FAIL conc_accept: got wr_ready=%b rd_aready=%b required 0 0", wr_ready, rd_aready); end
`ifdef DDR_WR_BEFORE_RD_EN
      exp_ar = 1'b0;
`else
      exp_ar = 1'b1;
`endif
      checks++; if (arvalid !== exp_ar) begin failures++; $display("[TB] FAIL conc_ar_c1: got %b required %b", arvalid, exp_ar); end
      @(negedge clk); awready = 1'b0; wready = 1'b0;
      checks++; if (arvalid !== 1'b0 || bready !== 1'b1) begin failures++; $display("[TB] FAIL conc_ar_c2: got arvalid=%b bready=%b required 0 1", arvalid, bready); end
      bvalid = 1'b1;
      @(negedge clk); bvalid = 1'b0;
`ifdef DDR_WR_BEFORE_RD_EN
      exp_ar = 1'b1;
`else
      exp_ar = 1'b0;
`endif
      checks++; if (arvalid !== exp_ar || wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL conc_ar_c3: got arvalid=%b wr_ready=%b required %b 1", arvalid, wr_ready, exp_ar); end
      @(negedge clk); arready = 1'b0;
      checks++; if (rready !== 1'b1) begin failures++; $display("[TB] FAIL conc_rready: got %b required 1", rready); end
      rvalid = 1'b1; rdata = 128'hFEEDFACE;
      @(negedge clk); rvalid = 1'b0; rdata = '0;
      checks++; if (rd_valid !== 1'b1 || rd_data !== 128'hFEEDFACE) begin failures++; $display("[TB] FAIL conc_rdata: got rd_valid=%b rd_data=%h", rd_valid, rd_data); end
      rd_dready = 1'b1;
      @(negedge clk); rd_dready = 1'b0;
      checks++; if (rd_aready !== 1'b1) begin failures++; $display("[TB] FAIL conc_rd_done: got %b required 1", rd_aready); end
   endtask

   task automatic do_read(input logic [26:0] addr, input logic [127:0] data, input string tag);
      rd_addr = addr; rd_avalid = 1'b1; arready = 1'b1;
      @(negedge clk); rd_avalid = 1'b0;
      checks++; if (arvalid !== 1'b1 || araddr !== addr) begin failures++; $display("[TB] FAIL %s_ar: got arvalid=%b araddr=%h required 1 %h", tag, arvalid, araddr, addr); end
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = data;
      @(negedge clk); rvalid = 1'b0; rdata = '0;
      checks++; if (rd_valid !== 1'b1 || rd_data !== data) begin failures++; $display("[TB] FAIL %s_data: got rd_valid=%b rd_data=%h required 1 %h", tag, rd_valid, rd_data, data); end
      rd_dready = 1'b1;
   endtask

   task automatic test_reset_mid_read();
      do_read(27'h0002220, 128'h5555AAAA, "pre_rst");
      #2 rst = 1'b1;
      #1;
      checks++; if (rd_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin failures++; $display("[TB] FAIL rst_async: got rd_valid=%b arvalid=%b rready=%b required 0 0 0", rd_valid, arvalid, rready); end
      @(negedge clk); rst = 1'b0; rd_dready = 1'b0;
      @(negedge clk);
      checks++; if (rd_aready !== 1'b1 || wr_ready !== 1'b1 || rd_data !== 128'd0 || araddr !== 27'd0) begin failures++; $display("[TB] FAIL rst_recover: got rd_aready=%b wr_ready=%b rd_data=%h araddr=%h", rd_aready, wr_ready, rd_data, araddr); end
      do_read(27'h0003330, 128'h0BADBEEF, "post_rst");
      @(negedge clk); rd_dready = 1'b0;
      checks++; if (rd_valid !== 1'b0 || rd_aready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_done: got rd_valid=%b rd_aready=%b required 0 1", rd_valid, rd_aready); end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = aw_log.size();
      awready = 1'b1; wready = 1'b1;
      wr_addr = 27'h0000100; wr_data = 128'h1; wr_valid = 1'b1;
      @(negedge clk); wr_valid = 1'b0;
      @(negedge clk); bvalid = 1'b1;
      @(negedge clk); bvalid = 1'b0;
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready1: got %b required 1", wr_ready); end
      wr_addr = 27'h0000200; wr_data = 128'h2; wr_valid = 1'b1;
      @(negedge clk); wr_valid = 1'b0;
      checks++; if (awaddr !== 27'h0000200 || wdata !== 128'h2 || wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_payload2: got awaddr=%h wdata=%h wr_ready=%b", awaddr, wdata, wr_ready); end
      @(negedge clk); bvalid = 1'b1;
      @(negedge clk); bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready2: got %b required 1", wr_ready); end
      checks++; if (aw_log.size() - n0 !== 2 || w_log.size() - n0 !== 2) begin failures++; $display("[TB] FAIL b2b_count: got aw=%0d w=%0d required 2 2", aw_log.size() - n0, w_log.size() - n0); end
      else begin
         checks++; if (aw_log[n0] !== 27'h0000100 || aw_log[n0+1] !== 27'h0000200 || w_log[n0] !== 128'h1 || w_log[n0+1] !== 128'h2) begin failures++; $display("[TB] FAIL b2b_log: got %h %h %h %h required 0000100 0000200 1 2", aw_log[n0], aw_log[n0+1], w_log[n0], w_log[n0+1]); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_independent_w_aw();
      test_concurrent();
      test_reset_mid_read();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
